// File: rtl/mem_seq_pkg.sv
// Shared types and lane helpers for the memory sequencer.
package mem_seq_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetchReq,
    StFetchWait,
    StDataReq,
    StDataWait,
    StIssue,
    StExec,
    StWbCheck,
    StWbWait
  } state_e;

  // Upper bound on MEM_W; lane helpers work on words zero-extended to this width.
  localparam int unsigned LaneMaxW = 1024;

  localparam logic [31:0] DefLoadMask  = 32'h0100_0040;
  localparam logic [31:0] DefStoreMask = 32'h0001_8040;

  function automatic logic [LaneMaxW-1:0] lane_mask(input int unsigned data_w);
    return {LaneMaxW{1'b1}} >> (LaneMaxW - data_w);
  endfunction

  // Extract lane `lane` of width data_w, right-aligned.
  function automatic logic [LaneMaxW-1:0] lane_sel(input logic [LaneMaxW-1:0] word,
                                                   input int unsigned data_w,
                                                   input int unsigned lane);
    return (word >> (lane * data_w)) & lane_mask(data_w);
  endfunction

  // Replace lane `lane` of word with lane_data.
  function automatic logic [LaneMaxW-1:0] lane_merge(input logic [LaneMaxW-1:0] word,
                                                     input logic [LaneMaxW-1:0] lane_data,
                                                     input int unsigned data_w,
                                                     input int unsigned lane);
    logic [LaneMaxW-1:0] m;
    m = lane_mask(data_w) << (lane * data_w);
    return (word & ~m) | ((lane_data & lane_mask(data_w)) << (lane * data_w));
  endfunction

endpackage

// File: rtl/mem_seq_linebuf.sv
// One-word data line buffer: word, tag, valid, lane read mux and lane merge.
module mem_seq_linebuf
  import mem_seq_pkg::*;
#(
  parameter int unsigned MEM_W  = 32,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MEM_AW = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic [MEM_W-1:0]  fill_data,
  input  logic [MEM_AW-1:0] fill_tag,
  input  logic              inval,
  input  logic [MEM_AW-1:0] addr,
  input  logic [31:0]       lane,
  input  logic [DATA_W-1:0] wdata,
  output logic              hit,
  output logic [DATA_W-1:0] rd_lane,
  output logic [MEM_W-1:0]  merged
);

  logic [MEM_W-1:0]  data_q;
  logic [MEM_AW-1:0] tag_q;
  logic              valid_q;

  // Buffer state; invalidation wins over a same-cycle fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if (inval) begin
      valid_q <= 1'b0;
    end else if (fill) begin
      data_q  <= fill_data;
      tag_q   <= fill_tag;
      valid_q <= 1'b1;
    end
  end

  // Hit detect, lane read and write-back merge.
  always_comb begin
    hit     = valid_q && (tag_q == addr);
    rd_lane = DATA_W'(lane_sel(LaneMaxW'(data_q), DATA_W, lane));
    merged  = MEM_W'(lane_merge(LaneMaxW'(data_q), LaneMaxW'(wdata), DATA_W, lane));
  end

endmodule

// File: rtl/mem_sequencer.sv
// Shared-port sequencer: instruction fetch, optional data read, lane
// presentation to the core and read-modify-write of the lane back to memory.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned MEM_W   = 32,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned INSTR_W = 25,
  parameter int unsigned MEM_AW  = 15,
  parameter int unsigned OPC_LSB = 20,
  parameter int unsigned OPC_W   = 5,
  parameter logic [(1<<OPC_W)-1:0] LOAD_MASK  = DefLoadMask,
  parameter logic [(1<<OPC_W)-1:0] STORE_MASK = DefStoreMask,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned LANES     = MEM_W / DATA_W,
  localparam int unsigned LOG_LANES = $clog2(LANES),
  localparam int unsigned DADDR_W   = MEM_AW + LOG_LANES
) (
  input  logic               clk,
  input  logic               rst,
  output logic [MEM_AW-1:0]  mem_addr,
  output logic [MEM_W-1:0]   mem_wdata,
  output logic               mem_we,
  output logic               mem_rstart,
  input  logic [MEM_W-1:0]   mem_rdata,
  input  logic               mem_rrdy,
  input  logic               mem_wrdy,
  input  logic [MEM_AW-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  input  logic [DADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  input  logic               d_we,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               cpu_stall,
  output logic               cpu_step,
  output logic               err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   ibuf_q, ibuf_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]    d_rdata_q, d_rdata_d;
  logic                 err_q, err_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [MEM_AW-1:0]    word_addr;
  logic [31:0]          lane;
  logic [OPC_W-1:0]     fetch_opc, instr_opc;
  logic                 in_wait, timeout_hit;

  logic                 buf_fill, buf_inval, buf_hit;
  logic [MEM_W-1:0]     buf_fill_data, buf_merged;
  logic [DATA_W-1:0]    buf_lane;

  // Address split, opcode fields and wait-timeout detect.
  always_comb begin
    word_addr   = MEM_AW'(d_addr >> LOG_LANES);
    lane        = 32'(d_addr & DADDR_W'(LANES - 1));
    fetch_opc   = mem_rdata[OPC_LSB +: OPC_W];
    instr_opc   = instr_q[OPC_LSB +: OPC_W];
    in_wait     = (state_q == StFetchWait) || (state_q == StDataWait) || (state_q == StWbWait);
    timeout_hit = (TIMEOUT != 0) && in_wait && (cnt_q == CntW'(TIMEOUT - 1));
    // Counter restarts at zero whenever a wait state is entered.
    cnt_d       = in_wait ? cnt_q + 1'b1 : '0;
  end

  mem_seq_linebuf #(
    .MEM_W  (MEM_W),
    .DATA_W (DATA_W),
    .MEM_AW (MEM_AW)
  ) u_linebuf (
    .clk       (clk),
    .rst       (rst),
    .fill      (buf_fill),
    .fill_data (buf_fill_data),
    .fill_tag  (word_addr),
    .inval     (buf_inval),
    .addr      (word_addr),
    .lane      (lane),
    .wdata     (d_wdata),
    .hit       (buf_hit),
    .rd_lane   (buf_lane),
    .merged    (buf_merged)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ibuf_q    <= '0;
      instr_q   <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ibuf_q    <= ibuf_d;
      instr_q   <= instr_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic and memory/core strobes.
  always_comb begin
    state_d       = state_q;
    ibuf_d        = ibuf_q;
    instr_d       = instr_q;
    d_rdata_d     = d_rdata_q;
    err_d         = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_we        = 1'b0;
    mem_rstart    = 1'b0;
    cpu_stall     = 1'b1;
    cpu_step      = 1'b0;
    buf_fill      = 1'b0;
    buf_fill_data = mem_rdata;
    buf_inval     = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetchReq;
      StFetchReq: begin
        mem_addr   = pc;
        mem_rstart = 1'b1;
        state_d    = StFetchWait;
      end
      StFetchWait: begin
        if (mem_rrdy) begin
          ibuf_d  = mem_rdata[INSTR_W-1:0];
          state_d = LOAD_MASK[fetch_opc] ? StDataReq : StIssue;
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          buf_inval = 1'b1;
          state_d   = StIdle;
        end
      end
      StDataReq: begin
        if (buf_hit) begin
          state_d = StIssue;
        end else begin
          mem_addr   = word_addr;
          mem_rstart = 1'b1;
          state_d    = StDataWait;
        end
      end
      StDataWait: begin
        if (mem_rrdy) begin
          buf_fill = 1'b1;
          state_d  = StIssue;
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          buf_inval = 1'b1;
          state_d   = StIdle;
        end
      end
      StIssue: begin
        instr_d   = ibuf_q;
        cpu_stall = 1'b0;
        state_d   = StExec;
      end
      StExec: begin
        cpu_stall = 1'b0;
        cpu_step  = 1'b1;
        d_rdata_d = buf_lane;
        state_d   = StWbCheck;
      end
      StWbCheck: begin
        cpu_stall = 1'b0;
        cpu_step  = 1'b1;
        if (STORE_MASK[instr_opc]) begin
          state_d = d_we ? StWbWait : StFetchReq;
        end else begin
          state_d = StIdle;
        end
      end
      StWbWait: begin
        mem_addr  = word_addr;
        mem_we    = 1'b1;
        mem_wdata = buf_merged;
        if (mem_wrdy) begin
          buf_fill      = 1'b1;
          buf_fill_data = buf_merged;
          state_d       = StFetchReq;
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          buf_inval = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign instr   = instr_q;
  assign d_rdata = d_rdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Scoreboarded bench for mem_sequencer: directed instruction slots against a
// small single-port memory model with one-cycle read/write response.
module tb_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_rstart;
  logic [31:0] mem_rdata = '0;
  logic        mem_rrdy = 1'b0;
  logic        mem_wrdy = 1'b0;
  logic [14:0] pc = '0;
  logic [24:0] instr;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_we = 1'b0;
  logic [15:0] d_rdata;
  logic        cpu_stall;
  logic        cpu_step;
  logic        err;

  logic        hold_rd = 1'b0;
  logic        hold_wr = 1'b0;
  int          n_reads = 0;
  int          n_writes = 0;
  int          n_err = 0;
  int          rd_base;
  int          n_vec = 0;
  int          n_bad = 0;

  typedef struct {
    logic [15:0] rd;
    logic [24:0] ins;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  mem_sequencer #(
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rstart (mem_rstart),
    .mem_rdata  (mem_rdata),
    .mem_rrdy   (mem_rrdy),
    .mem_wrdy   (mem_wrdy),
    .pc         (pc),
    .instr      (instr),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_we       (d_we),
    .d_rdata    (d_rdata),
    .cpu_stall  (cpu_stall),
    .cpu_step   (cpu_step),
    .err        (err)
  );

  // Memory image: word 1 is data, words 8..13 are instructions (opcode in [24:20]).
  logic [31:0] mem [16] = '{32'h0, 32'hAAAA_5555, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                            32'h0180_0001, 32'h0180_0002, 32'h0060_0003, 32'h00F0_0004,
                            32'h0180_0006, 32'h0100_0005, 32'h0, 32'h0};

  // Memory model: read data one cycle after mem_rstart; write acked one cycle into mem_we.
  always @(posedge clk) begin
    mem_rrdy <= mem_rstart && !hold_rd;
    if (mem_rstart) begin
      mem_rdata <= mem[mem_addr[3:0]];
      n_reads   <= n_reads + 1;
    end
    mem_wrdy <= mem_we && !mem_wrdy && !hold_wr;
    if (mem_we && mem_wrdy) begin
      mem[mem_addr[3:0]] <= mem_wdata;
      n_writes           <= n_writes + 1;
    end
    if (err) n_err <= n_err + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: the second consecutive cpu_step cycle is WB_CHECK, where d_rdata
  // already holds the lane registered in EXEC.
  initial begin : monitor
    exp_t e;
    logic step_prev;
    step_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_step && step_prev) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb_unexpected: core step with no expected entry, instr 0x%0h", instr);
        end else begin
          e = sbq.pop_front();
          chk("sb_d_rdata", 64'(d_rdata), 64'(e.rd));
          chk("sb_instr", 64'(instr), 64'(e.ins));
        end
      end
      step_prev = cpu_step;
    end
  end

  task automatic chk_reset(input string pfx);
    chk({pfx, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({pfx, "_mem_rstart"}, 64'(mem_rstart), 64'd0);
    chk({pfx, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({pfx, "_cpu_stall"}, 64'(cpu_stall), 64'd1);
    chk({pfx, "_cpu_step"}, 64'(cpu_step), 64'd0);
    chk({pfx, "_err"}, 64'(err), 64'd0);
    chk({pfx, "_instr"}, 64'(instr), 64'd0);
    chk({pfx, "_d_rdata"}, 64'(d_rdata), 64'd0);
  endtask

  task automatic start_slot(input logic [14:0] p, input logic [15:0] da, input logic we,
                            input logic [15:0] wd, input logic [15:0] e_rd,
                            input logic [24:0] e_ins);
    pc      = p;
    d_addr  = da;
    d_we    = we;
    d_wdata = wd;
    rd_base = n_reads;
    sbq.push_back('{rd: e_rd, ins: e_ins});
  endtask

  // Waits through EXEC/WB_CHECK, then checks what follows WB_CHECK.
  task automatic finish_slot(input string name, input logic store, input logic wait_wr,
                             input logic e_fetch, input int e_reads,
                             input logic [14:0] e_waddr, input logic [31:0] e_wdata);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!cpu_step && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!cpu_step) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_step_wait: no cpu_step within %0d cycles, expected one", name, cyc);
      return;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    if (store) begin
      chk({name, "_we"}, 64'(mem_we), 64'd1);
      chk({name, "_waddr"}, 64'(mem_addr), 64'(e_waddr));
      chk({name, "_wdata"}, 64'(mem_wdata), 64'(e_wdata));
      if (wait_wr) begin
        cyc = 0;
        while (mem_we && cyc < 50) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        chk({name, "_wr_done"}, 64'(mem_we), 64'd0);
        chk({name, "_fetch"}, 64'(mem_rstart), 64'(e_fetch));
      end
    end else begin
      chk({name, "_fetch"}, 64'(mem_rstart), 64'(e_fetch));
      chk({name, "_no_we"}, 64'(mem_we), 64'd0);
    end
    chk({name, "_reads"}, 64'(n_reads - rd_base), 64'(e_reads));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst0");
    rst = 1'b0;

    // Load miss: fetch + data read, upper lane of word 1.
    start_slot(15'd8, 16'h0003, 1'b0, 16'h0, 16'hAAAA, 25'h180_0001);
    finish_slot("ld_miss", 1'b0, 1'b0, 1'b0, 2, 15'd0, 32'd0);

    // Load hit on the same word: fetch only, lower lane.
    start_slot(15'd9, 16'h0002, 1'b0, 16'h0, 16'h5555, 25'h180_0002);
    finish_slot("ld_hit", 1'b0, 1'b0, 1'b0, 1, 15'd0, 32'd0);

    // Opcode 6 is load- and store-class: buffer hit, then merge-write lane 0.
    start_slot(15'd10, 16'h0002, 1'b1, 16'h1234, 16'h5555, 25'h060_0003);
    finish_slot("st6", 1'b1, 1'b1, 1'b1, 1, 15'd1, 32'hAAAA_1234);
    chk("st6_mem1", 64'(mem[1]), 64'hAAAA_1234);
    chk("st6_writes", 64'(n_writes), 64'd1);

    // Opcode 15 without d_we: no write, straight back to FETCH_REQ; reads updated buffer.
    start_slot(15'd11, 16'h0003, 1'b0, 16'h0, 16'hAAAA, 25'h0F0_0004);
    finish_slot("st15_nowe", 1'b0, 1'b0, 1'b1, 1, 15'd0, 32'd0);
    chk("st15_writes", 64'(n_writes), 64'd1);

    // Fetch timeout: err after 8 wait cycles, retry same pc, buffer now invalid.
    hold_rd = 1'b1;
    start_slot(15'd12, 16'h0003, 1'b0, 16'h0, 16'hAAAA, 25'h180_0006);
    @(negedge clk);
    chk("to_req", 64'(mem_rstart), 64'd1);
    chk("to_addr", 64'(mem_addr), 64'd12);
    cyc = 0;
    while (!err && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_latency", 64'(cyc), 64'd9);
    hold_rd = 1'b0;
    rd_base = n_reads;
    @(negedge clk);
    chk("to_pulse", 64'(err), 64'd0);
    chk("to_refetch", 64'(mem_rstart), 64'd1);
    chk("to_pc", 64'(mem_addr), 64'd12);
    finish_slot("to_retry", 1'b0, 1'b0, 1'b0, 2, 15'd0, 32'd0);

    // Store opcode 16 held in WB_WAIT, then reset: write must be abandoned.
    hold_wr = 1'b1;
    start_slot(15'd13, 16'h0002, 1'b1, 16'hBEEF, 16'h1234, 25'h100_0005);
    finish_slot("st16", 1'b1, 1'b0, 1'b0, 1, 15'd1, 32'hAAAA_BEEF);
    repeat (3) @(posedge clk);
    #3;
    rst     = 1'b1;
    hold_wr = 1'b0;
    #1;
    chk_reset("rst_wb");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_mem1", 64'(mem[1]), 64'hAAAA_1234);
    chk("rst_wb_writes", 64'(n_writes), 64'd1);
    rst = 1'b0;

    // After reset the buffer is empty: load misses again.
    start_slot(15'd9, 16'h0002, 1'b0, 16'h0, 16'h1234, 25'h180_0002);
    finish_slot("post_rst", 1'b0, 1'b0, 1'b0, 2, 15'd0, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    chk("err_pulses", 64'(n_err), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
